// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with bypass and busy scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  localparam logic [31:0] ZERO_ADDR = 32'd0;

  // A write (or alloc) takes effect unless it targets the hardwired-zero register.
  function automatic logic eff_write(input logic en, input logic [31:0] addr, input logic zero_reg);
    return en & ~(zero_reg & (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write and allocate bus of the register file; the decode stage drives it as master.
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_mp_sb_bypass.sv
// One read port: picks the newest in-flight write over the array word and masks busy when bypassed.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        arr_word,
  input  logic                     busy_bit,
  input  logic                     bypass_en,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic [NUM_WR-1:0] match_s;
  logic [DATA_W-1:0] data_s;
  logic              hit_s;
  logic              is_zero_s;

  // Priority scan: later (higher-index) write ports overwrite earlier matches.
  always_comb begin
    match_s = '0;
    data_s  = arr_word;
    hit_s   = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      match_s[j] = bypass_en
                 & eff_write(wr_en[j], 32'(wr_addr[j*ADDR_W +: ADDR_W]), ZERO_REG != 0)
                 & (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr);
      data_s     = match_s[j] ? wr_data[j*DATA_W +: DATA_W] : data_s;
      hit_s      = hit_s | match_s[j];
    end
  end

  assign is_zero_s = (ZERO_REG != 0) && (rd_addr == '0);
  assign rd_data   = is_zero_s ? '0 : data_s;
  assign rd_busy   = ~is_zero_s & bypass_en & busy_bit & ~hit_s;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass and a per-register busy scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           reset,
  regfile_mp_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic              wr_conflict_r;

  logic [NUM_WR-1:0] eff_s;
  logic              alloc_eff_s;
  logic              conflict_s;
  logic [DEPTH-1:0]  wr_mask_s;
  logic [DEPTH-1:0]  alloc_mask_s;
  logic [DEPTH-1:0]  busy_next_s;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_eff
    assign eff_s[j] = eff_write(bus.wr_en[j], 32'(bus.wr_addr[j*ADDR_W +: ADDR_W]), ZERO_REG != 0);
  end

  assign alloc_eff_s = eff_write(bus.alloc_en, 32'(bus.alloc_addr), ZERO_REG != 0);

  if (NUM_WR == 2) begin : g_conf
    assign conflict_s = eff_s[0] & eff_s[1]
                      & (bus.wr_addr[0 +: ADDR_W] == bus.wr_addr[ADDR_W +: ADDR_W]);
  end else begin : g_noconf
    assign conflict_s = 1'b0;
  end

  // Scoreboard update: writes retire producers, then a same-cycle alloc re-marks the register.
  always_comb begin
    wr_mask_s = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_mask_s = wr_mask_s | (eff_s[j] ? (DEPTH'(1'b1) << bus.wr_addr[j*ADDR_W +: ADDR_W]) : '0);
    end
    alloc_mask_s = alloc_eff_s ? (DEPTH'(1'b1) << bus.alloc_addr) : '0;
    busy_next_s  = (busy_r & ~wr_mask_s) | alloc_mask_s;
  end

  // Storage, scoreboard and conflict flag; ascending port order lets the highest port win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
      busy_r        <= '0;
      wr_conflict_r <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (eff_s[j]) begin
          mem_r[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
        end
      end
      busy_r        <= busy_next_s;
      wr_conflict_r <= conflict_s;
    end
  end

  assign bus.wr_conflict = wr_conflict_r;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = bus.rd_addr[i*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .rd_addr  (addr_s),
      .arr_word (mem_r[addr_s]),
      .busy_bit (busy_r[addr_s]),
      .bypass_en(reset),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_data  (data_s),
      .rd_busy  (busy_s)
    );

    assign bus.rd_data[i*DATA_W +: DATA_W] = data_s;
    assign bus.rd_busy[i]                  = busy_s;
  end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port register file with an integrated write-to-read bypass and a per-register busy scoreboard, for the pipelined processor's decode stage. It generalises the single-write, dual-read register file:
- configurable data width, depth, read-port count and write-port count;
- rising-edge writes with same-cycle forwarding instead of a negedge write;
- an optional hardwired-zero register 0;
- busy tracking so hazard logic can stall on in-flight producers.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2); higher index = higher priority
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, bypassed
- rd_busy  out  NUM_RD  addressed register awaits a producer, combinational
- wr_en  in  NUM_WR  write strobes
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  1  mark alloc_addr busy (instruction issued with this destination)
- alloc_addr  in  ADDR_W  destination being allocated
- wr_conflict  out  1  registered pulse: two write ports hit the same effective address last cycle

## Operation
- Write: at each rising edge, for each j with wr_en[j]=1, registers[wr_addr[j]] <= wr_data[j]. Same address on both ports: port NUM_WR-1 wins.
- ZERO_REG=1:
  - writes to address 0 are dropped and alloc to address 0 is dropped;
  - rd_data reads 0 and rd_busy reads 0 for address 0.
- Read, per port i:
  - If any wr_en[j] matches rd_addr[i] (effective, not a dropped write to 0), rd_data[i] = wr_data of the highest-index match (bypass).
  - Otherwise rd_data[i] = registers[rd_addr[i]].
- Scoreboard: busy[2**ADDR_W] bit vector.
  - Effective write to address a clears busy[a].
  - alloc_en sets busy[alloc_addr].
  - Alloc and write to the same address in the same cycle: busy ends set (new producer wins).
- rd_busy[i] = busy[rd_addr[i]] AND NOT (an effective write to rd_addr[i] this cycle). Bypassed data is valid, so the port does not report busy.
- wr_conflict:
  - next value = 1 when NUM_WR=2, both wr_en set, and addresses are equal and effective; else 0.
  - Data resolution is unchanged by the flag.
- Reset (reset=0 at an edge):
  - all registers <= 0, busy <= 0, wr_conflict <= 0;
  - reset overrides writes and alloc in the same cycle.
- While reset=0: bypass and rd_busy are forced off, so rd_data reflects the array only.

## Timing
- Write latency: data written at edge N is readable from the array after edge N. During cycle N it is already visible via bypass, i.e. zero-cycle read-after-write.
- Busy set by alloc at edge N: rd_busy=1 from cycle N+1 until the cycle the matching write is presented. rd_busy drops combinationally in that cycle.
- wr_conflict: 1-cycle registered pulse, asserted in cycle N+1 for a conflict in cycle N.
- Reset values after the first reset edge: every register 0, every busy 0, rd_data=0 for all addresses, rd_busy=0, wr_conflict=0.
- Reset mid-operation: pending allocs are discarded; no busy bit survives.
- No multicycle paths. rd_data and rd_busy are combinational from rd_addr/wr_* and must close within one cycle with the downstream decode logic.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD/NUM_WR constants;
  - the zero-register address constant;
  - a function computing effective-write (enable AND not-zero-when-ZERO_REG).
- Sub-module regfile_bypass_mux, instantiated once per read port via generate:
  - takes rd_addr, array word, busy bit and all write ports;
  - returns rd_data and rd_busy with highest-index priority.
- Top holds the storage array, busy vector, conflict flop and write/alloc update logic.

## Test plan
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, wr_conflict=0 for every address.
- Write port0 r5=0xDEADBEEF, same cycle read r5 -> rd_data=0xDEADBEEF (bypass); next cycle without write -> still 0xDEADBEEF from the array.
- Write r0=0x1234 and alloc r0 -> r0 reads 0, rd_busy=0, no wr_conflict.
- Both ports write r7 (0x11 on port0, 0x22 on port1) -> same-cycle read 0x22, later read 0x22, wr_conflict=1 for exactly one cycle after.
- alloc r9 -> rd_busy=1 next cycle; write r9=0x55 three cycles later -> rd_busy=0 and rd_data=0x55 in that cycle; alloc+write r9 together -> busy stays 1.
- Write r3=0xA5 and alloc r4, assert reset=0 in the same cycle -> r3 reads 0, r4 not busy, bypass suppressed during reset.
